// File: rtl/rv_pkg.sv
// Shared RV32M types: multiply/divide opcodes, unit FSM states and operand-signedness helpers.
// Pure declarations, so there is no latency and no backpressure.
package rv_pkg;

  typedef enum logic [2:0] {
    MD_MUL,
    MD_MULH,
    MD_MULHSU,
    MD_MULHU,
    MD_DIV,
    MD_DIVU,
    MD_REM,
    MD_REMU
  } md_operations_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } md_state_e;

  function automatic logic md_a_signed(input md_operations_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input md_operations_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/rv_muldiv.sv
// Iterative RV32M mul/div: XLEN+2 cycles to valid_o, 1 cycle for div-by-zero/overflow.
// Accepts only when idle; holds the result until ready_i; flush_i kills at any point.
module rv_muldiv
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      md_ctrl_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_INC  = CW'(1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q;
  md_operations_e    op_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_prod_q;
  logic              neg_rem_q;
  logic [XLEN-1:0]   result_q;
  logic              valid_q;
  logic              zero_q;

  md_operations_e  op_in;
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            is_div, div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;

  assign op_in  = md_operations_e'(md_ctrl_i);
  assign sa     = md_a_signed(op_in) & operand_a_i[XLEN-1];
  assign sb     = md_b_signed(op_in) & operand_b_i[XLEN-1];
  assign mag_a  = sa ? -operand_a_i : operand_a_i;
  assign mag_b  = sb ? -operand_b_i : operand_b_i;
  assign is_div = md_ctrl_i[2];

  assign div_zero = is_div && (operand_b_i == '0);
  assign div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                    (operand_a_i == XMIN) && (operand_b_i == '1);

  // Bit 1 of the opcode separates remainder ops from quotient ops.
  always_comb begin
    fast_res = '0;
    if (div_zero)     fast_res = md_ctrl_i[1] ? operand_a_i : '1;
    else if (div_ovf) fast_res = md_ctrl_i[1] ? '0 : XMIN;
  end

  // Multiply: acc = {partial sum, remaining multiplier bits}, opnd = multiplicand.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}, opnd = divisor.
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_res;
  assign prod = neg_prod_q ? -acc_q : acc_q;
  assign quot = acc_q[XLEN-1:0];
  assign rem  = acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op_q)
      MD_MUL:                       fix_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res = neg_prod_q ? -quot : quot;
      MD_REM, MD_REMU:              fix_res = neg_rem_q ? -rem : rem;
      default:                      fix_res = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= MD_IDLE;
      op_q       <= MD_MUL;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else if (flush_i) begin
      state_q  <= MD_IDLE;
      result_q <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (valid_i) begin
            op_q       <= op_in;
            cnt_q      <= '0;
            neg_prod_q <= sa ^ sb;
            neg_rem_q  <= sa;
            if (div_zero || div_ovf) begin
              state_q  <= MD_DONE;
              result_q <= fast_res;
              zero_q   <= (fast_res == '0);
              valid_q  <= 1'b1;
            end else begin
              state_q <= MD_CALC;
              acc_q   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
              opnd_q  <= is_div ? mag_b : mag_a;
            end
          end
        end
        MD_CALC: begin
          acc_q <= op_q[2] ? div_next : mul_next;
          cnt_q <= cnt_q + CNT_INC;
          if (cnt_q == CNT_LAST) state_q <= MD_FIX;
        end
        MD_FIX: begin
          state_q  <= MD_DONE;
          result_q <= fix_res;
          zero_q   <= (fix_res == '0);
          valid_q  <= 1'b1;
        end
        MD_DONE: begin
          if (ready_i) begin
            state_q  <= MD_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q == MD_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule
